pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the program counter register and sequences instruction fetch for the 32-bit processor. Each cycle it selects the next PC from sequential (PC+4), conditional branch, absolute jump or register jump, and applies stall, halt and address-error control. It sits between the control unit / hazard logic and instruction memory, with PCResult driving the fetch address.

## Interface

- RESET_VECTOR, 32'h00000000, PC value loaded on reset; must be word-aligned.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard stall; holds PC, ignores redirects.
- HaltReq  input  1  request to enter HALT.
- Resume  input  1  leave HALT; sampled only in HALT.
- Branch  input  1  taken conditional branch this cycle.
- BranchImm  input  16  signed word offset of the branch.
- Jump  input  1  absolute jump (j/jal).
- JumpIndex  input  26  jump instruction index field.
- JumpReg  input  1  register jump (jr/jalr).
- RegTarget  input  32  register jump target address.
- PCResult  output  32  current PC (registered).
- PCAddResult  output  32  PCResult + 4, combinational, modulo 2^32.
- Valid  output  1  PCResult is a fetch to be executed.
- Flush  output  1  one-cycle pulse: the PC was just redirected.
- Halted  output  1  high in HALT state.
- AddrError  output  1  sticky misaligned register-jump flag.

## Operation

- States: BOOT, RUN, STALL, HALT. Encoding is free.
- Reset: state=BOOT, PCResult=RESET_VECTOR, Valid=0, Flush=0, Halted=0, AddrError=0.
- BOOT -> RUN unconditionally after one cycle. PC is unchanged. All control inputs are ignored.
- RUN/STALL decision priority, evaluated each cycle:
  1. HaltReq -> HALT, PC held.
  2. Stall -> STALL, PC held, all redirects dropped.
  3. JumpReg -> if RegTarget[1:0]!=0: AddrError=1, HALT, PC held. Otherwise PC=RegTarget.
  4. Jump -> PC={PCAddResult[31:28], JumpIndex, 2'b00}.
  5. Branch -> PC=PCAddResult + (sign-extended BranchImm << 2).
  6. Otherwise PC=PCAddResult.
- After any of cases 3–6 the state is RUN.
- STALL with Stall low behaves exactly as RUN in that cycle; there is no extra bubble.
- HALT: PC held, Valid=0, Halted=1, redirects ignored.
  - Resume=1 and AddrError=0 -> RUN, PC unchanged.
  - If AddrError=1, only Reset leaves HALT.
- All arithmetic is 32-bit unsigned, modulo 2^32. Carries out are discarded, so 0xFFFFFFFC+4 = 0x00000000. Branch targets wrap the same way.
- AddrError is cleared only by Reset.

## Timing

- PCResult, Valid, Flush, Halted and AddrError are registered and update on the rising edge of Clk.
- Valid=1 in RUN and STALL; 0 in BOOT and HALT.
- A redirect (case 3 with aligned target, 4 or 5) sampled at edge N gives the new PCResult and Flush=1 after edge N. Flush returns to 0 after edge N+1 unless another redirect occurs.
- Sequential advance has one-cycle latency: PCResult steps by 4 each non-stalled RUN cycle.
- The first fetch (Valid=1) occurs two edges after Reset deasserts: BOOT, then RUN.
- Reset asserted in any state or mid-redirect wins on the next edge. No Flush is emitted.
- Simultaneous Branch+Jump+JumpReg resolve by the priority above. Stall and HaltReq override all of them.

## Test plan

- Reset, then 4 free-running cycles -> PCResult 0,0,4,8,12; Valid 0,1,1,1,1; Flush stays 0.
- PC=0x00000100, Branch=1, BranchImm=16'hFFFF -> next PCResult=0x00000100, Flush=1 for one cycle. Then BranchImm=16'h0003 -> 0x00000110.
- PC=0x1000_0000, Jump=1, JumpIndex=26'h0000040 -> PCResult=0x1000_0100. Jump+Branch together -> jump target wins.
- PC forced to 0xFFFFFFF8, run 2 cycles -> 0xFFFFFFFC, then 0x00000000. PCAddResult at 0xFFFFFFFC reads 0x00000000.
- Stall=1 together with Jump=1 for 3 cycles -> PC held, Flush=0. Stall drops -> PC+4 next edge. HaltReq -> Halted=1, Valid=0. Resume -> RUN with PC unchanged.
- JumpReg=1, RegTarget=0x00000402 -> AddrError=1, Halted=1, PC unchanged. Resume ignored. Reset -> PC=RESET_VECTOR, AddrError=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Owns the program counter and sequences instruction fetch. Each cycle the
// next PC is chosen from sequential advance (PC+4), a taken conditional
// branch, an absolute jump or a register jump. Stall, halt and
// register-jump alignment errors are handled here as well.
//
// Ports:
//   Clk          rising-edge clock
//   Reset        synchronous active-high reset
//   Stall        hazard stall: hold PC and drop any redirect
//   HaltReq      request to enter HALT
//   Resume       leave HALT (only honoured when no address error is latched)
//   Branch       taken conditional branch, offset BranchImm (signed words)
//   Jump         absolute jump, target built from JumpIndex
//   JumpReg      register jump to RegTarget
//   PCResult     current fetch address (registered)
//   PCAddResult  PCResult + 4 (combinational, wraps modulo 2^32)
//   Valid        PCResult is a fetch to be executed
//   Flush        one-cycle pulse after the PC was redirected
//   Halted       sequencer is in HALT
//   AddrError    sticky flag: a register jump targeted a misaligned address
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        HaltReq,
    input  logic        Resume,
    input  logic        Branch,
    input  logic [15:0] BranchImm,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    output logic [31:0] PCResult,
    output logic [31:0] PCAddResult,
    output logic        Valid,
    output logic        Flush,
    output logic        Halted,
    output logic        AddrError
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic        flush_next;
    logic        addr_err_next;

    // Branch target: sequential PC plus the sign-extended word offset.
    // The add is done on 32 bits so any carry out is simply discarded.
    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic signed [15:0] imm);
        logic [31:0] offset;
        offset = {{14{imm[15]}}, imm, 2'b00};
        return base + offset;
    endfunction

    // Absolute jump keeps the region bits of the sequential PC.
    function automatic logic [31:0] jump_target(input logic [31:0] base,
                                                input logic [25:0] index);
        return {base[31:28], index, 2'b00};
    endfunction

    assign PCAddResult = PCResult + 32'd4;

    always_comb begin
        state_next    = state;
        pc_next       = PCResult;
        flush_next    = 1'b0;
        addr_err_next = AddrError;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN, STALL: begin
                // STALL with Stall low is treated exactly like RUN, so both
                // states share the same priority chain.
                if (HaltReq) begin
                    state_next = HALT;
                end else if (Stall) begin
                    state_next = STALL;
                end else if (JumpReg) begin
                    if (RegTarget[1:0] != 2'b00) begin
                        addr_err_next = 1'b1;
                        state_next    = HALT;
                    end else begin
                        pc_next    = RegTarget;
                        flush_next = 1'b1;
                        state_next = RUN;
                    end
                end else if (Jump) begin
                    pc_next    = jump_target(PCAddResult, JumpIndex);
                    flush_next = 1'b1;
                    state_next = RUN;
                end else if (Branch) begin
                    pc_next    = branch_target(PCAddResult, BranchImm);
                    flush_next = 1'b1;
                    state_next = RUN;
                end else begin
                    pc_next    = PCAddResult;
                    state_next = RUN;
                end
            end
            HALT: begin
                // A latched address error pins the sequencer here until reset.
                if (Resume && !AddrError) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the PC they describe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= BOOT;
            PCResult  <= RESET_VECTOR;
            Valid     <= 1'b0;
            Flush     <= 1'b0;
            Halted    <= 1'b0;
            AddrError <= 1'b0;
        end else begin
            state     <= state_next;
            PCResult  <= pc_next;
            Valid     <= (state_next == RUN) || (state_next == STALL);
            Flush     <= flush_next;
            Halted    <= (state_next == HALT);
            AddrError <= addr_err_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a driver applies directed and random control
// input patterns, predicts the registered outputs with a behavioural model
// and queues them; a monitor pops and compares after every clock edge.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STALL = 2;
    localparam int M_HALT  = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        HaltReq = 1'b0;
    logic        Resume = 1'b0;
    logic        Branch = 1'b0;
    logic [15:0] BranchImm = 16'h0;
    logic        Jump = 1'b0;
    logic [25:0] JumpIndex = 26'h0;
    logic        JumpReg = 1'b0;
    logic [31:0] RegTarget = 32'h0;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        Valid;
    logic        Flush;
    logic        Halted;
    logic        AddrError;

    pc_sequencer #(.RESET_VECTOR(RV)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .HaltReq(HaltReq),
        .Resume(Resume), .Branch(Branch), .BranchImm(BranchImm),
        .Jump(Jump), .JumpIndex(JumpIndex), .JumpReg(JumpReg),
        .RegTarget(RegTarget), .PCResult(PCResult),
        .PCAddResult(PCAddResult), .Valid(Valid), .Flush(Flush),
        .Halted(Halted), .AddrError(AddrError)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        halted;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   drive_done = 1'b0;

    // Reference model state
    int          m_mode = M_BOOT;
    logic [31:0] m_pc = RV;
    bit          m_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input bit rst, input bit stl, input bit hr, input bit rs,
                        input bit br, input logic [15:0] bi, input bit jp,
                        input logic [25:0] ji, input bit jr, input logic [31:0] rt);
        logic [31:0] seq;
        bit          fl;
        exp_t        e;
        @(negedge Clk);
        Reset = rst; Stall = stl; HaltReq = hr; Resume = rs;
        Branch = br; BranchImm = bi; Jump = jp; JumpIndex = ji;
        JumpReg = jr; RegTarget = rt;
        fl = 1'b0;
        if (rst) begin
            m_mode = M_BOOT; m_pc = RV; m_err = 1'b0;
        end else if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (rs && !m_err) m_mode = M_RUN;
        end else if (hr) begin
            m_mode = M_HALT;
        end else if (stl) begin
            m_mode = M_STALL;
        end else if (jr && (rt % 4 != 0)) begin
            m_err = 1'b1; m_mode = M_HALT;
        end else begin
            seq = m_pc + 32'd4;
            m_mode = M_RUN;
            if (jr) begin
                m_pc = rt; fl = 1'b1;
            end else if (jp) begin
                m_pc = (seq & 32'hF000_0000) | (32'(ji) * 32'd4); fl = 1'b1;
            end else if (br) begin
                m_pc = 32'(longint'(seq) + longint'($signed(bi)) * 4); fl = 1'b1;
            end else begin
                m_pc = seq;
            end
        end
        e.pc     = m_pc;
        e.valid  = (m_mode == M_RUN) || (m_mode == M_STALL);
        e.flush  = fl;
        e.halted = (m_mode == M_HALT);
        e.err    = m_err;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    endtask

    task automatic jreg(input logic [31:0] t);
        step(0, 0, 0, 0, 0, 16'h0, 0, 26'h0, 1, t);
    endtask

    // Monitor: compare every DUT output against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                cyc++;
                e = q.pop_front();
                chk("PCResult", PCResult, e.pc);
                chk("PCAddResult", PCAddResult, e.pc + 32'd4);
                chk("Valid", 32'(Valid), 32'(e.valid));
                chk("Flush", 32'(Flush), 32'(e.flush));
                chk("Halted", 32'(Halted), 32'(e.halted));
                chk("AddrError", 32'(AddrError), 32'(e.err));
            end
        end
    end

    // Driver
    initial begin
        // Reset and free run
        step(1, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        idle(4);
        // Branch back onto itself, then forward
        jreg(32'h0000_00FC);
        idle(1);
        step(0, 0, 0, 0, 1, 16'hFFFF, 0, 26'h0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 16'h0003, 0, 26'h0, 0, 32'h0);
        idle(1);
        // Absolute jump, then jump beating branch and jump-reg beating both
        jreg(32'h0FFF_FFFC);
        step(0, 0, 0, 0, 0, 16'h0, 1, 26'h0000040, 0, 32'h0);
        step(0, 0, 0, 0, 1, 16'h0010, 1, 26'h0000080, 0, 32'h0);
        step(0, 0, 0, 0, 1, 16'h0010, 1, 26'h0000080, 1, 32'h0000_2000);
        // Address wrap
        jreg(32'hFFFF_FFF8);
        idle(2);
        step(0, 0, 0, 0, 1, 16'h0004, 0, 26'h0, 0, 32'h0);
        // Stall over redirects, halt, resume
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 16'h0, 1, 26'h0000123, 0, 32'h0);
        idle(1);
        step(0, 1, 1, 0, 1, 16'h0001, 1, 26'h0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 16'h0001, 1, 26'h0, 1, 32'h40);
        step(0, 0, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        idle(2);
        // Misaligned register jump locks HALT until reset
        jreg(32'h0000_0402);
        step(0, 0, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        step(0, 0, 0, 1, 0, 16'h0, 1, 26'h1, 0, 32'h0);
        step(1, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        idle(3);
        // Reset mid-redirect
        step(1, 0, 0, 0, 1, 16'h0100, 1, 26'h55, 0, 32'h0);
        idle(2);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 7) != 0) rt[1:0] = 2'b00;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, 16'($urandom),
                 $urandom_range(0, 3) == 0, 26'($urandom),
                 $urandom_range(0, 5) == 0, rt);
        end
        drive_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!drive_done && budget < 20000) begin
            @(posedge Clk);
            budget++;
        end
        repeat (3) @(posedge Clk);
        #2;
        checks++;
        if (!drive_done || q.size() != 0) begin
            errors++;
            $display("FAIL drain: driver done %0d, pending %0d expected 0", drive_done, q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
